// File: rtl/lane_mux_ser_pkg.sv
// lane_mux_ser_pkg: shared constants and parameter helpers for the lane-ratio serializer
package lane_mux_ser_pkg;

    localparam logic [7:0] IDLE_CHAR_DEF = 8'hBC;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++)
            if ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int ratio_of(input int num_in, input int num_out);
        return num_in / num_out;
    endfunction

    function automatic bit legal_cfg(input int num_in, input int num_out);
        return (num_out > 0) && (num_in >= num_out) && (num_in % num_out == 0);
    endfunction

endpackage

// File: rtl/lane_mux_ser_if.sv
// lane_mux_ser_if: word input handshake, beat output handshake and overflow flag
interface lane_mux_ser_if #(
    parameter int DATA_W  = 8,
    parameter int NUM_IN  = 4,
    parameter int NUM_OUT = 2
);
    logic [NUM_IN*DATA_W-1:0]  in_data;
    logic [NUM_IN-1:0]         in_valid;
    logic                      in_stb;
    logic                      in_rdy;
    logic [NUM_OUT*DATA_W-1:0] out_data;
    logic [NUM_OUT-1:0]        out_valid;
    logic                      out_stb;
    logic                      out_rdy;
    logic                      ovf_err;

    modport master (
        output in_data, in_valid, in_stb, out_rdy,
        input  in_rdy, out_data, out_valid, out_stb, ovf_err
    );

    modport slave (
        input  in_data, in_valid, in_stb, out_rdy,
        output in_rdy, out_data, out_valid, out_stb, ovf_err
    );
endinterface

// File: rtl/lane_word_fifo.sv
// lane_word_fifo: 2-entry word buffer with wrap pointers and occupancy count
module lane_word_fifo #(
    parameter int W = 36
) (
    input  logic         clk,
    input  logic         reset_L,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] head,
    output logic [1:0]   count
);
    logic [W-1:0] mem [2];
    logic         wp, rp;

    assign head = mem[rp];

    // storage, pointers and count; simultaneous push/pop leaves count unchanged
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wp     <= 1'b0;
            rp     <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wp] <= wdata;
                wp      <= ~wp;
            end
            if (pop) rp <= ~rp;
            count <= count + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: rtl/lane_mux_ser.sv
// lane_mux_ser: NUM_IN->NUM_OUT lane serializer; define LANE_MUX_SER_IDLE_FILL_EN for idle-symbol fill
module lane_mux_ser
    import lane_mux_ser_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                NUM_IN    = 4,
    parameter int                NUM_OUT   = 2,
    parameter logic [DATA_W-1:0] IDLE_CHAR = DATA_W'(IDLE_CHAR_DEF)
) (
    input  logic          clk,
    input  logic          reset_L,
    lane_mux_ser_if.slave bus
);
    localparam int RATIO = ratio_of(NUM_IN, NUM_OUT);
    localparam int CNT_W = clog2(RATIO);
    localparam int W     = NUM_IN * DATA_W + NUM_IN;
`ifdef LANE_MUX_SER_IDLE_FILL_EN
    localparam bit FILL_EN = 1'b1;
`else
    localparam bit FILL_EN = 1'b0;
`endif
    localparam logic [NUM_OUT*DATA_W-1:0] IDLE_WORD = {NUM_OUT{IDLE_CHAR}};
    localparam logic [NUM_OUT*DATA_W-1:0] RST_DATA  = FILL_EN ? IDLE_WORD : '0;

    generate
        if (!legal_cfg(NUM_IN, NUM_OUT)) begin : g_bad_cfg
            $error("lane_mux_ser: NUM_IN must be a non-zero multiple of NUM_OUT");
        end
    endgenerate

    logic [W-1:0]              head;
    logic [1:0]                count;
    logic [CNT_W-1:0]          cnt;
    logic [NUM_IN*DATA_W-1:0]  head_data;
    logic [NUM_IN-1:0]         head_valid;
    logic [NUM_OUT*DATA_W-1:0] beat_data;
    logic [NUM_OUT-1:0]        beat_valid;
    logic                      adv, nonempty, last, push, pop;

    assign bus.in_rdy = (count != 2'd2) && reset_L;
    assign push       = bus.in_stb && bus.in_rdy;
    assign adv        = !bus.out_stb || bus.out_rdy;
    assign nonempty   = count != 2'd0;
    assign last       = cnt == CNT_W'(RATIO - 1);
    assign pop        = adv && nonempty && last;
    assign head_data  = head[W-1:NUM_IN];
    assign head_valid = head[NUM_IN-1:0];

    lane_word_fifo #(.W(W)) u_fifo (
        .clk     (clk),
        .reset_L (reset_L),
        .push    (push),
        .pop     (pop),
        .wdata   ({bus.in_data, bus.in_valid}),
        .head    (head),
        .count   (count)
    );

    // beat cnt of the head word: output lane k takes input lane k*RATIO+cnt
    always_comb begin
        beat_data  = '0;
        beat_valid = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            beat_data[k*DATA_W +: DATA_W] = head_data[(k*RATIO + int'(cnt))*DATA_W +: DATA_W];
            beat_valid[k]                 = head_valid[k*RATIO + int'(cnt)];
        end
    end

    // output register, beat counter and sticky overflow flag
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            bus.out_data  <= RST_DATA;
            bus.out_valid <= '0;
            bus.out_stb   <= 1'b0;
            bus.ovf_err   <= 1'b0;
            cnt           <= '0;
        end else begin
            if (bus.in_stb && !bus.in_rdy) bus.ovf_err <= 1'b1;
            if (adv) begin
                if (nonempty) begin
                    bus.out_data  <= beat_data;
                    bus.out_valid <= beat_valid;
                    bus.out_stb   <= 1'b1;
                    cnt           <= last ? '0 : cnt + 1'b1;
                end else begin
                    bus.out_data  <= FILL_EN ? IDLE_WORD : bus.out_data;
                    bus.out_valid <= '0;
                    bus.out_stb   <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_lane_mux_ser.sv
// tb_lane_mux_ser: vector table, corner sequences and random traffic against a queue-based model
module tb_lane_mux_ser;
    localparam int DW = 8;
    localparam int NI = 4;
    localparam int NO = 2;
    localparam int R  = NI / NO;
    localparam int IW = NI * DW;
    localparam int OW = NO * DW;
`ifdef LANE_MUX_SER_IDLE_FILL_EN
    localparam bit            FILL = 1'b1;
    localparam logic [OW-1:0] IDLE = {NO{8'hBC}};
`else
    localparam bit            FILL = 1'b0;
    localparam logic [OW-1:0] IDLE = '0;
`endif

    logic clk = 1'b0;
    logic reset_L = 1'b0;
    always #5 clk = ~clk;

    lane_mux_ser_if #(.DATA_W(DW), .NUM_IN(NI), .NUM_OUT(NO)) bus ();
    lane_mux_ser #(.DATA_W(DW), .NUM_IN(NI), .NUM_OUT(NO)) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus)
    );

    typedef struct {
        logic [IW-1:0] d;
        logic [NI-1:0] v;
    } word_t;

    typedef struct {
        logic [IW-1:0] d;
        logic [NI-1:0] v;
        logic [OW-1:0] d0;
        logic [NO-1:0] v0;
        logic [OW-1:0] d1;
        logic [NO-1:0] v1;
    } vec_t;

    word_t         wq[$];
    int            mb;
    logic          mstb, movf;
    logic [OW-1:0] mdata;
    logic [NO-1:0] mvalid;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0h want %0h", n, a, e);
        end
    endtask

    function automatic logic [OW-1:0] bdata(input word_t w, input int b);
        logic [OW-1:0] r;
        r = '0;
        for (int k = 0; k < NO; k++) r[k*DW +: DW] = w.d[(k*R + b)*DW +: DW];
        return r;
    endfunction

    function automatic logic [NO-1:0] bvalid(input word_t w, input int b);
        logic [NO-1:0] r;
        r = '0;
        for (int k = 0; k < NO; k++) r[k] = w.v[k*R + b];
        return r;
    endfunction

    task automatic mreset();
        wq.delete();
        mb     = 0;
        mstb   = 1'b0;
        movf   = 1'b0;
        mvalid = '0;
        mdata  = IDLE;
    endtask

    task automatic model_edge(input logic s, input logic [IW-1:0] d, input logic [NI-1:0] v, input logic r);
        bit rdy;
        rdy = wq.size() < 2;
        if (s && !rdy) movf = 1'b1;
        if (!mstb || r) begin
            if (wq.size() > 0) begin
                mdata  = bdata(wq[0], mb);
                mvalid = bvalid(wq[0], mb);
                mstb   = 1'b1;
                mb++;
                if (mb == R) begin
                    mb = 0;
                    void'(wq.pop_front());
                end
            end else begin
                mstb   = 1'b0;
                mvalid = '0;
                if (FILL) mdata = IDLE;
            end
        end
        if (s && rdy) wq.push_back('{d: d, v: v});
    endtask

    task automatic check_all(input string tag);
        chk({tag, " in_rdy"}, bus.in_rdy, reset_L && (wq.size() < 2));
        chk({tag, " out_stb"}, bus.out_stb, mstb);
        chk({tag, " out_data"}, bus.out_data, mdata);
        chk({tag, " out_valid"}, bus.out_valid, mvalid);
        chk({tag, " ovf_err"}, bus.ovf_err, movf);
    endtask

    task automatic cyc(input logic s, input logic [IW-1:0] d, input logic [NI-1:0] v, input logic r, input string tag);
        bus.in_stb   = s;
        bus.in_data  = d;
        bus.in_valid = v;
        bus.out_rdy  = r;
        model_edge(s, d, v, r);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input int n);
        reset_L    = 1'b0;
        bus.in_stb = 1'b0;
        #1;
        mreset();
        check_all("rst_assert");
        repeat (n) @(posedge clk);
        #1;
        check_all("rst_hold");
        reset_L = 1'b1;
        #1;
        check_all("rst_release");
    endtask

    vec_t          tv[4];
    logic [OW-1:0] held;
    bit            gap, stall;

    initial begin
        tv[0] = '{32'hA3A2A1A0, 4'hF,    16'hA2A0, 2'b11, 16'hA3A1, 2'b11};
        tv[1] = '{32'h0D0C0B0A, 4'b0101, 16'h0C0A, 2'b11, 16'h0D0B, 2'b00};
        tv[2] = '{32'h44332211, 4'b1000, 16'h3311, 2'b00, 16'h4422, 2'b10};
        tv[3] = '{32'hDDCCBBAA, 4'b0110, 16'hCCAA, 2'b10, 16'hDDBB, 2'b01};

        bus.in_stb   = 1'b0;
        bus.in_data  = '0;
        bus.in_valid = '0;
        bus.out_rdy  = 1'b1;
        mreset();
        @(posedge clk);
        #1;
        do_reset(3);

        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, tv[i].d, tv[i].v, 1'b1, "tv_push");
            cyc(1'b0, '0, '0, 1'b1, "tv_b0");
            chk("tv beat0 data", bus.out_data, tv[i].d0);
            chk("tv beat0 valid", bus.out_valid, tv[i].v0);
            cyc(1'b0, '0, '0, 1'b1, "tv_b1");
            chk("tv beat1 data", bus.out_data, tv[i].d1);
            chk("tv beat1 valid", bus.out_valid, tv[i].v1);
            cyc(1'b0, '0, '0, 1'b1, "tv_idle");
            chk("tv idle stb", bus.out_stb, 1'b0);
        end

        gap   = 1'b0;
        stall = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, IW'($urandom), NI'($urandom), 1'b1, "b2b_push");
            if (i > 0 && !bus.out_stb) gap = 1'b1;
            if (!bus.in_rdy) stall = 1'b1;
            cyc(1'b0, '0, '0, 1'b1, "b2b_gap");
            if (!bus.out_stb) gap = 1'b1;
            if (!bus.in_rdy) stall = 1'b1;
        end
        chk("b2b out_stb gap", gap, 1'b0);
        chk("b2b in_rdy drop", stall, 1'b0);
        chk("b2b ovf", bus.ovf_err, 1'b0);
        repeat (3) cyc(1'b0, '0, '0, 1'b1, "b2b_drain");

        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, IW'($urandom), 4'hF, 1'b0, "stall");
            if (i == 2) held = bus.out_data;
        end
        chk("stall in_rdy", bus.in_rdy, 1'b0);
        chk("stall data stable", bus.out_data, held);
        chk("stall ovf", bus.ovf_err, 1'b1);
        repeat (6) cyc(1'b0, '0, '0, 1'b1, "stall_release");
        chk("stall drained", bus.out_stb, 1'b0);

        cyc(1'b1, 32'h11223344, 4'hF, 1'b1, "mid_w1");
        cyc(1'b1, 32'h55667788, 4'hF, 1'b1, "mid_w2");
        chk("mid beat0 stb", bus.out_stb, 1'b1);
        do_reset(1);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, '0, '0, 1'b1, "mid_after");
            chk("mid no beats", bus.out_stb, 1'b0);
            chk("mid in_rdy", bus.in_rdy, 1'b1);
        end

        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 2) != 0, IW'($urandom), NI'($urandom),
                $urandom_range(0, 3) != 0, "rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lane_mux_ser.md
# lane_mux_ser

Parametrised lane-ratio serializer for the PHY transmit path: it accepts one word of NUM_IN parallel lanes per handshake and emits it as RATIO = NUM_IN/NUM_OUT consecutive beats on NUM_OUT lanes, all on a single clock, with ready/strobe flow control in both directions. It sits between the per-lane byte sources and the lane striper/serializer stage. A 2-entry word buffer lets the block sustain one input word every RATIO cycles.

## Interface
- DATA_W, 8, bits per lane
- NUM_IN, 4, input lanes; must be a multiple of NUM_OUT
- NUM_OUT, 2, output lanes; RATIO = NUM_IN/NUM_OUT (≥1)
- IDLE_CHAR, 8'hBC, idle fill symbol (used only with LANE_MUX_SER_IDLE_FILL_EN); width DATA_W
---
- clk  input  1  single clock; all state on rising edge
- reset_L  input  1  asynchronous active-low reset
- in_data  input  NUM_IN*DATA_W  lane i at bits [i*DATA_W +: DATA_W]
- in_valid  input  NUM_IN  per-lane valid, carried with its byte
- in_stb  input  1  word offered this cycle
- in_rdy  output  1  word buffer can accept; word taken when in_stb && in_rdy at a rising edge
- out_data  output  NUM_OUT*DATA_W  registered beat data, lane k at [k*DATA_W +: DATA_W]
- out_valid  output  NUM_OUT  registered per-lane valid
- out_stb  output  1  registered; beat present on out_data/out_valid
- out_rdy  input  1  downstream takes the beat when out_stb && out_rdy
- ovf_err  output  1  sticky: in_stb asserted while in_rdy low

## Operation
- Lane mapping: on beat b (0..RATIO-1), output lane k carries input lane k*RATIO + b (data and valid together). For 4→2: beat 0 = {lane0, lane2}, beat 1 = {lane1, lane3}.
- Word buffer: 2 entries, 1-bit wrap pointers plus count 0..2. in_rdy = (count != 2) && reset_L.
- Output register advances when !out_stb || out_rdy ("advance"). On advance: if buffer non-empty, load beat cnt of head word, out_stb<=1, cnt++; on cnt == RATIO-1, cnt<=0 and head is popped. If buffer empty, out_stb<=0.
- Push and pop on the same edge: count unchanged, both pointers move.
- Full: in_rdy low; in_stb ignored (word dropped by upstream contract) and ovf_err set, cleared only by reset.
- out_stb && !out_rdy: out_data/out_valid/out_stb held stable, cnt frozen.
- RATIO=1: block is a 2-deep registered pipeline, one beat per word.
- Reset (asynchronous assert, any time including mid-word): buffer flushed, pointers/count/cnt = 0, out_stb=0, out_valid=0, out_data=0 (IDLE_CHAR per lane with macro), ovf_err=0, in_rdy=0 while reset_L low. Partially sent word is discarded; no remaining beats after release.

## Timing
- Latency: word accepted at edge T, output idle → beat 0 visible after edge T+1, beat b after edge T+1+b with out_rdy high.
- Throughput: one word per RATIO cycles sustained with out_rdy=1; in_rdy never drops in that case.
- in_rdy is combinational from registered count only (no path from in_stb or out_rdy).
- out_rdy → advance is combinational into register enables only; all outputs registered.

## Configuration
- LANE_MUX_SER_IDLE_FILL_EN defined: when out_stb=0 (reset and whenever the buffer empties), every out_data lane = IDLE_CHAR, out_valid=0.
- Not defined: out_data holds last beat when idle (0 after reset), out_valid=0.

## Structure
- Shared package: IDLE_CHAR default constant, clog2 function, RATIO/CNT_W localparam derivation, parameter legality checks (NUM_IN % NUM_OUT == 0).
- One sub-module: lane_word_fifo (2-entry word+valid buffer, push/pop/count, async active-low reset); lane selection and output register in lane_mux_ser.

## Test plan
- Reset: hold reset_L low 3 cycles → in_rdy=0, out_stb=0, out_valid=2'b00, out_data=0 (16'hBCBC with macro); first cycle after release in_rdy=1.
- Single word in_data lanes {0:8'hA0,1:8'hA1,2:8'hA2,3:8'hA3}, in_valid=4'hF at edge T → after T+1 out_data {lane0:A0,lane1:A2}, after T+2 {A1,A3}, after T+3 out_stb=0.
- Back-to-back words every 2 cycles, out_rdy=1, 20 words → out_stb continuously 1, in_rdy never 0, beat order exact, ovf_err=0.
- out_rdy=0 for 6 cycles with in_stb held → 2 words accepted, in_rdy=0 thereafter, out_data stable, ovf_err=1; on release all beats arrive in order, none lost.
- in_valid=4'b0101 → beat 0 out_valid=2'b11, beat 1 out_valid=2'b00.
- reset_L pulsed low after beat 0 of a word with a second word buffered → no further beats after release, count=0, in_rdy=1.
